// File: rtl/sipo_pkg.sv
// Shared types and helpers for the framed serial-in/parallel-out controller.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int unsigned clog2w(input int unsigned v);
    int unsigned r;
    r = $clog2(v);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in and parallel-out signal bundle for sipo_frame_ctrl.
// master: serial front end plus parallel consumer; slave: the controller.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  import sipo_pkg::*;

  localparam int CW = clog2w(WIDTH);

  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             abort;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             sync_err;

  modport master (
    output sin, sin_valid, sof, abort, dout_ready,
    input  dout, dout_valid, busy, bit_cnt, overrun, sync_err
  );

  modport slave (
    input  sin, sin_valid, sof, abort, dout_ready,
    output dout, dout_valid, busy, bit_cnt, overrun, sync_err
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register; newest bit enters at the LSB.
// clear with shift_en restarts the word with the incoming bit as bit 0.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Shift contents: clear wins over hold, clear+shift starts a fresh word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear && shift_en) begin
      q <= {{(WIDTH-1){1'b0}}, sin};
    end else if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed SIPO controller: start-of-frame alignment, bit counting, one-entry
// output buffer with valid/ready drain, overrun and resync pulses.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for sof; bits without sof are ignored
//   SHIFT | assembling words; streams word after word without new sof
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  sipo_frame_ctrl_if.slave  bus
);

  localparam int            CW   = clog2w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] new_word;
  logic             sof_hit;
  logic             bit_fire;
  logic             word_done;
  logic             sr_clear;

  // Reset asserts immediately, releases two clocks after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  assign sof_hit   = bus.sin_valid && bus.sof && !bus.abort;
  assign bit_fire  = bus.sin_valid && !bus.abort && (bus.sof || state_q == SHIFT);
  assign word_done = bit_fire && !bus.sof && (bit_cnt_q == LAST);
  assign sr_clear  = bus.abort || sof_hit;
  assign new_word  = {sr_q[WIDTH-2:0], bus.sin};

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset    (rst_n_int),
    .shift_en (bit_fire),
    .clear    (sr_clear),
    .sin      (bus.sin),
    .q        (sr_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state, counter, output buffer and event pulses.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    sync_err_d   = 1'b0;

    if (bus.abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (sof_hit) begin
      state_d    = SHIFT;
      bit_cnt_d  = CW'(1);
      sync_err_d = (state_q == SHIFT) && (bit_cnt_q != '0);
    end else if (bit_fire) begin
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
    end

    // A completing word may replace the buffer only if it empties this edge.
    if (dout_valid_q && bus.dout_ready) dout_valid_d = 1'b0;
    if (word_done) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = new_word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Datapath registers for counter, buffer and pulses.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.overrun    = overrun_q;
  assign bus.sync_err   = sync_err_q;

endmodule
